// File: rtl/dmem_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Package : lsu_pkg
// Brief   : Shared encodings, state type and alignment helper for dmem_lsu.
// Rev     : 1.0  initial release
// ============================================================================
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } lsu_state_t;

  // Size 11 is treated as an error alongside real misalignment so callers
  // need only one test to decide whether memory may be touched.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module : lsu_lane_align
// Brief  : Little-endian lane extraction/extension for loads and lane merge
//          of store data into the current memory word (combinational).
// Rev    : 1.0  initial release
// ============================================================================
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rd,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane and extend it to a full word.
  always_comb begin
    byte_sel  = rd[{addr_lo, 3'b000} +: 8];
    half_sel  = addr_lo[1] ? rd[31:16] : rd[15:0];
    load_data = rd;
    case (size)
      SZ_BYTE: load_data = is_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = is_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data = rd;
    endcase
  end

  // Overlay the right-justified store data onto the addressed lane.
  always_comb begin
    merged = rd;
    case (size)
      SZ_BYTE: merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (addr_lo[1]) merged = {wdata[15:0], rd[15:0]};
        else            merged = {rd[31:16], wdata[15:0]};
      end
      default: merged = wdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module : dmem_lsu
// Brief  : Load/store unit converting byte/half/word requests into word
//          accesses on a combinational-read, edge-write data memory.
//          Sub-word stores are done as read (accept cycle) then write.
// Rev    : 1.0  initial release
// ============================================================================
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd
);

  lsu_state_t  state, state_next;
  logic        accept;
  logic        req_err;
  logic        sub_store;
  logic [31:0] req_word_addr;
  logic [31:0] load_data;
  logic [31:0] merged_data;
  logic [31:0] saved_addr;
  logic [31:0] merged_q;

  assign req_word_addr = 32'(req_addr) & 32'hFFFF_FFFC;
  assign req_err       = misaligned(req_size, req_addr[1:0]);
  assign sub_store     = accept && req_we && !req_err && (req_size != SZ_WORD);

  lsu_lane_align u_lane_align (
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .addr_lo     (req_addr[1:0]),
    .rd          (mem_rd),
    .wdata       (req_wdata),
    .load_data   (load_data),
    .merged      (merged_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and memory-port drive; reset gates the write enable directly
  // so a pending WRITE is dropped the moment rst_n falls.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    accept     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = req_word_addr;
    mem_wd     = req_wdata;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        accept    = req_valid;
        if (req_valid && req_we && !req_err) begin
          if (req_size == SZ_WORD) mem_we = 1'b1;
          else                     state_next = WRITE;
        end
      end
      WRITE: begin
        mem_we     = 1'b1;
        mem_addr   = saved_addr;
        mem_wd     = merged_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (!rst_n) mem_we = 1'b0;
  end

  // Capture the merged word and its address for the following WRITE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      saved_addr <= 32'd0;
      merged_q   <= 32'd0;
    end else if (sub_store) begin
      saved_addr <= req_word_addr;
      merged_q   <= merged_data;
    end
  end

  // One-cycle response pulse; sub-word stores respond after their WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      if (state == WRITE) begin
        resp_valid <= 1'b1;
      end else if (accept) begin
        if (req_err) begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
        end else if (!req_we) begin
          resp_valid <= 1'b1;
          resp_rdata <= load_data;
        end else if (req_size == SZ_WORD) begin
          resp_valid <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module : tb_dmem_lsu
// Brief  : Directed self-checking bench for dmem_lsu with a small word memory.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dmem_lsu;
  import lsu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:63];
  int          we_count;
  int          checks;
  int          errors;

  dmem_lsu #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wd       (mem_wd),
    .mem_rd       (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write at the rising edge.
  assign mem_rd = (mem_addr[31:8] == 24'd0 && mem_addr[1:0] == 2'b00) ?
                  mem[mem_addr[7:2]] : 32'hDEAD_DEAD;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wd;
      we_count <= we_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd);
    req_valid    = v;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int we_before;
    checks   = 0;
    errors   = 0;
    we_count = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[0] = 32'h1111_1111;
    mem[1] = 32'h2222_2222;
    mem[2] = 32'h3333_3333;
    mem[4] = 32'h8BAD_F00D;
    mem[6] = 32'hCAFE_BABE;

    // Reset held with a word store presented: nothing may be written.
    rst_n = 1'b0;
    drive(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hFFFF_FFFF);
    #3;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    edge_wait();
    edge_wait();
    chk("rst_no_write", mem[4], 32'h8BAD_F00D);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);

    // Sub-word loads from 0x8BADF00D.
    @(negedge clk);
    drive(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0);
    #1;
    chk("ld_b_memaddr", mem_addr, 32'h10);
    edge_wait();
    chk("ld_b_s_valid", {31'd0, resp_valid}, 32'd1);
    chk("ld_b_s_data", resp_rdata, 32'hFFFF_FF8B);
    chk("ld_b_s_err", {31'd0, resp_err}, 32'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0);
    edge_wait();
    chk("ld_b_u_data", resp_rdata, 32'h0000_008B);
    @(negedge clk);
    drive(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h10, 32'h0);
    edge_wait();
    chk("ld_h_s_data", resp_rdata, 32'hFFFF_F00D);

    // Half store 0xBEEF at 0x12 (upper wdata bits must be ignored).
    @(negedge clk);
    drive(1'b1, 1'b1, SZ_HALF, 1'b0, 32'h12, 32'h1234_BEEF);
    #1;
    chk("st_h_acc_we", {31'd0, mem_we}, 32'd0);
    chk("st_h_acc_ready", {31'd0, req_ready}, 32'd1);
    edge_wait();
    chk("st_h_wr_ready", {31'd0, req_ready}, 32'd0);
    chk("st_h_wr_we", {31'd0, mem_we}, 32'd1);
    chk("st_h_wr_wd", mem_wd, 32'hBEEF_F00D);
    chk("st_h_wr_addr", mem_addr, 32'h10);
    chk("st_h_wr_novalid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    edge_wait();
    chk("st_h_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("st_h_resp_rdata", resp_rdata, 32'd0);
    chk("st_h_ready_back", {31'd0, req_ready}, 32'd1);
    chk("st_h_we_once", we_count, 32'd1);
    edge_wait();
    chk("ld_after_h_valid", {31'd0, resp_valid}, 32'd1);
    chk("ld_after_h_data", resp_rdata, 32'hBEEF_F00D);

    // Misaligned and illegal requests.
    we_before = we_count;
    @(negedge clk);
    drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h06, 32'h0);
    edge_wait();
    chk("err_w_valid", {31'd0, resp_valid}, 32'd1);
    chk("err_w_err", {31'd0, resp_err}, 32'd1);
    chk("err_w_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    drive(1'b1, 1'b1, SZ_HALF, 1'b0, 32'h11, 32'hAAAA_5555);
    #1;
    chk("err_h_st_we", {31'd0, mem_we}, 32'd0);
    edge_wait();
    chk("err_h_st_err", {31'd0, resp_err}, 32'd1);
    chk("err_h_st_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b11, 1'b1, 32'h00, 32'h0);
    edge_wait();
    chk("err_sz11_err", {31'd0, resp_err}, 32'd1);
    chk("err_sz11_rdata", resp_rdata, 32'd0);
    chk("err_no_writes", we_count, we_before);
    chk("err_mem_intact", mem[4], 32'hBEEF_F00D);

    // Back-to-back word loads.
    @(negedge clk);
    drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0);
    edge_wait();
    chk("b2b0_valid", {31'd0, resp_valid}, 32'd1);
    chk("b2b0_data", resp_rdata, 32'h1111_1111);
    @(negedge clk);
    drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h04, 32'h0);
    edge_wait();
    chk("b2b1_valid", {31'd0, resp_valid}, 32'd1);
    chk("b2b1_data", resp_rdata, 32'h2222_2222);
    @(negedge clk);
    drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0);
    edge_wait();
    chk("b2b2_valid", {31'd0, resp_valid}, 32'd1);
    chk("b2b2_data", resp_rdata, 32'h3333_3333);

    // Word store then immediate load of the same word.
    @(negedge clk);
    drive(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h1234_5678);
    #1;
    chk("st_w_we", {31'd0, mem_we}, 32'd1);
    chk("st_w_wd", mem_wd, 32'h1234_5678);
    edge_wait();
    chk("st_w_valid", {31'd0, resp_valid}, 32'd1);
    chk("st_w_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0);
    edge_wait();
    chk("ld_after_w", resp_rdata, 32'h1234_5678);
    @(negedge clk);
    drive(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    edge_wait();
    chk("idle_no_valid", {31'd0, resp_valid}, 32'd0);

    // Reset during the WRITE cycle of a byte store over 0xCAFEBABE.
    @(negedge clk);
    drive(1'b1, 1'b1, SZ_BYTE, 1'b0, 32'h19, 32'h0000_00A5);
    edge_wait();
    chk("rw_we", {31'd0, mem_we}, 32'd1);
    chk("rw_wd", mem_wd, 32'hCAFE_A5BE);
    chk("rw_addr", mem_addr, 32'h18);
    @(negedge clk);
    drive(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("rw_we_drop", {31'd0, mem_we}, 32'd0);
    chk("rw_ready", {31'd0, req_ready}, 32'd1);
    chk("rw_valid", {31'd0, resp_valid}, 32'd0);
    chk("rw_rdata", resp_rdata, 32'd0);
    chk("rw_err", {31'd0, resp_err}, 32'd0);
    edge_wait();
    chk("rw_mem_unchanged", mem[6], 32'hCAFE_BABE);
    @(negedge clk);
    rst_n = 1'b1;
    edge_wait();
    chk("rw_no_resp", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h19, 32'h0);
    edge_wait();
    chk("rw_ld_valid", {31'd0, resp_valid}, 32'd1);
    chk("rw_ld_data", resp_rdata, 32'h0000_00BA);
    @(negedge clk);
    drive(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    edge_wait();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
